// File: rtl/vshift_seq.sv
// Sequential vector shift: walks active elements through an external element shifter,
// one per cycle. Define VSHIFT_SEQ_MASK_EN to honour the vm element mask.
module vshift_seq #(
   parameter  int VLEN     = 64,
   parameter  int ELEN     = 8,
   localparam int NUM_ELEM = VLEN / ELEN,
   localparam int IDX_W    = $clog2(NUM_ELEM),
   localparam int SH_W     = $clog2(ELEN)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [1:0]          op,
   input  logic [VLEN-1:0]     vs2,
   input  logic [VLEN-1:0]     vs1,
   input  logic [IDX_W:0]      vl,
   input  logic [NUM_ELEM-1:0] vm,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [VLEN-1:0]     res_data,
   output logic [ELEN-1:0]     sh_src,
   output logic [SH_W-1:0]     sh_shift,
   output logic                sh_shift_left,
   output logic                sh_shift_arith,
   output logic [ELEN-1:0]     sh_shift_in,
   input  logic [ELEN-1:0]     sh_result
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [IDX_W:0] NUM_ELEM_V = (IDX_W + 1)'(NUM_ELEM);

   state_t                               r_state;
   state_t                               w_state_next;
   logic [1:0]                           r_op;
   logic [NUM_ELEM-1:0][ELEN-1:0]        r_vs2;
   logic [NUM_ELEM-1:0][SH_W-1:0]        r_sh;
   logic [NUM_ELEM-1:0][ELEN-1:0]        r_buf;
   logic [IDX_W:0]                       r_vl;
   logic [IDX_W-1:0]                     r_idx;
   logic [NUM_ELEM-1:0][SH_W-1:0]        w_sh_amt;
   logic [IDX_W:0]                       w_vl_clamp;
   logic                                 w_accept;
   logic                                 w_last;
   logic                                 w_active;

   // Only the low SH_W bits of each shift-amount element matter to the shifter.
   for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_sh_amt
      assign w_sh_amt[gi] = vs1[gi*ELEN +: SH_W];
   end
   wire w_unused_vs1 = ^vs1;

   assign w_vl_clamp  = (vl > NUM_ELEM_V) ? NUM_ELEM_V : vl;
   assign w_accept    = (r_state == S_IDLE) && op_valid;
   assign w_last      = ({1'b0, r_idx} == (r_vl - (IDX_W + 1)'(1)));
   assign res_data    = r_buf;
   assign sh_shift_in = '0;

`ifdef VSHIFT_SEQ_MASK_EN
   logic [NUM_ELEM-1:0] r_vm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vm <= '0;
      end else if (w_accept) begin
         r_vm <= vm;
      end
   end

   assign w_active = r_vm[r_idx];
`else
   wire w_unused_vm = ^vm;
   assign w_active = 1'b1;
`endif

   always_comb begin
      w_state_next   = r_state;
      op_ready       = 1'b0;
      res_valid      = 1'b0;
      sh_src         = '0;
      sh_shift       = '0;
      sh_shift_left  = 1'b0;
      sh_shift_arith = 1'b0;
      case (r_state)
         S_IDLE: begin
            op_ready = 1'b1;
            if (op_valid) begin
               w_state_next = ((w_vl_clamp == '0) || (op == 2'b11)) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            sh_src         = r_vs2[r_idx];
            sh_shift       = r_sh[r_idx];
            sh_shift_left  = (r_op == 2'b00);
            sh_shift_arith = (r_op == 2'b10);
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_vs2   <= '0;
         r_sh    <= '0;
         r_buf   <= '0;
         r_vl    <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op  <= op;
            r_vs2 <= vs2;
            r_sh  <= w_sh_amt;
            r_buf <= vs2;
            r_vl  <= w_vl_clamp;
            r_idx <= '0;
         end else if (r_state == S_RUN) begin
            // Inactive elements keep the vs2 value loaded at accept.
            if (w_active) begin
               r_buf[r_idx] <= sh_result;
            end
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vshift_seq.sv
// Bench for vshift_seq: behavioural element shifter plus a scoreboard of expected
// result vectors and latencies.
module tb_vshift_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op;
   logic [63:0] vs2;
   logic [63:0] vs1;
   logic [3:0]  vl;
   logic [7:0]  vm;
   logic        res_valid;
   logic        res_ready;
   logic [63:0] res_data;
   logic [7:0]  sh_src;
   logic [2:0]  sh_shift;
   logic        sh_shift_left;
   logic        sh_shift_arith;
   logic [7:0]  sh_shift_in;
   logic [7:0]  sh_result;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] q_data[$];
   int          q_lat[$];

   always #5 clk = ~clk;

   vshift_seq #(.VLEN(64), .ELEN(8)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .vs2(vs2), .vs1(vs1), .vl(vl), .vm(vm), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .sh_src(sh_src),
      .sh_shift(sh_shift), .sh_shift_left(sh_shift_left),
      .sh_shift_arith(sh_shift_arith), .sh_shift_in(sh_shift_in),
      .sh_result(sh_result)
   );

   // External element shifter.
   always_comb begin
      sh_result = 8'h00;
      if (sh_shift_left)       sh_result = sh_src << sh_shift;
      else if (sh_shift_arith) sh_result = 8'($signed(sh_src) >>> sh_shift);
      else                     sh_result = sh_src >> sh_shift;
   end

   function automatic logic [7:0] elem_shift(input logic [1:0] o, input logic [7:0] a,
                                             input logic [2:0] s);
      logic [7:0] r;
      case (o)
         2'b00:   r = a << s;
         2'b01:   r = a >> s;
         2'b10:   r = 8'($signed(a) >>> s);
         default: r = a;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] model(input logic [1:0] o, input logic [63:0] a,
                                         input logic [63:0] b, input logic [3:0] l,
                                         input logic [7:0] m);
      logic [63:0] r;
      int          n;
      logic        act;
      r = a;
      n = (l > 4'd8) ? 8 : int'(l);
      if (o != 2'b11) begin
         for (int i = 0; i < n; i++) begin
            act = 1'b1;
`ifdef VSHIFT_SEQ_MASK_EN
            act = m[i];
`endif
            if (act) r[i*8 +: 8] = elem_shift(o, a[i*8 +: 8], b[i*8 +: 3]);
         end
      end
      return r;
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] l, input logic [7:0] m, input int hold,
                         input logic [63:0] exp_data, input string name);
      int          n;
      int          t;
      int          cnt;
      int          exp_lat;
      logic [63:0] d;
      n       = (l > 4'd8) ? 8 : int'(l);
      exp_lat = ((n == 0) || (o == 2'b11)) ? 1 : n + 1;
      q_data.push_back(exp_data);
      q_lat.push_back(exp_lat);

      t = 0;
      while (!op_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_tests++;
      if (!op_ready) begin
         n_fail++;
         $display("FAIL %s op_ready timeout: got %b want 1", name, op_ready);
      end
      op_valid = 1'b1; op = o; vs2 = a; vs1 = b; vl = l; vm = m;
      @(posedge clk);
      cnt = 0;
      forever begin
         @(negedge clk);
         op_valid = 1'b0;
         if (res_valid || cnt >= 40) break;
         n_tests++;
         if (cnt < 8 && (sh_src !== a[cnt*8 +: 8] || sh_shift !== b[cnt*8 +: 3] ||
                         sh_shift_left !== (o == 2'b00) || sh_shift_arith !== (o == 2'b10) ||
                         sh_shift_in !== 8'h00 || op_ready !== 1'b0)) begin
            n_fail++;
            $display("FAIL %s run_drive idx %0d: got src %h sh %0d l %b a %b in %h rdy %b want src %h sh %0d l %b a %b in 00 rdy 0",
                     name, cnt, sh_src, sh_shift, sh_shift_left, sh_shift_arith, sh_shift_in,
                     op_ready, a[cnt*8 +: 8], b[cnt*8 +: 3], o == 2'b00, o == 2'b10);
         end
         @(posedge clk);
         cnt++;
      end

      exp_lat  = q_lat.pop_front();
      d        = q_data.pop_front();
      n_tests += 3;
      if (cnt + 1 !== exp_lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, cnt + 1, exp_lat);
      end
      if (res_data !== d) begin
         n_fail++;
         $display("FAIL %s res_data: got %h want %h", name, res_data, d);
      end
      if (sh_src !== 8'h00 || sh_shift !== 3'd0 || sh_shift_left || sh_shift_arith) begin
         n_fail++;
         $display("FAIL %s sh_idle_done: got src %h sh %0d l %b a %b want all 0",
                  name, sh_src, sh_shift, sh_shift_left, sh_shift_arith);
      end
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         @(negedge clk);
         n_tests++;
         if (res_valid !== 1'b1 || res_data !== d || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s hold %0d: got valid %b data %h rdy %b want valid 1 data %h rdy 0",
                     name, k, res_valid, res_data, op_ready, d);
         end
      end
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
      n_tests++;
      if (res_valid !== 1'b0 || op_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s release: got valid %b rdy %b want valid 0 rdy 1",
                  name, res_valid, op_ready);
      end
      $display("[TB] %s op=%0d vl=%0d latency=%0d data=%h", name, o, l, cnt + 1, res_data);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (op_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 64'h0 ||
          sh_src !== 8'h00 || sh_shift !== 3'd0 || sh_shift_left !== 1'b0 ||
          sh_shift_arith !== 1'b0 || sh_shift_in !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state: got rdy %b valid %b data %h src %h sh %0d l %b a %b in %h want 1 0 0 0 0 0 0 0",
                  op_ready, res_valid, res_data, sh_src, sh_shift, sh_shift_left,
                  sh_shift_arith, sh_shift_in);
      end
      $display("[TB] reset state checked");
   endtask

   task automatic test_sll();
      run_op(2'b00, {8{8'h81}}, {8{8'h09}}, 4'd8, 8'hFF, 0, {8{8'h02}}, "sll_full");
   endtask

   task automatic test_sra_srl();
      run_op(2'b10, 64'h80, 64'h03, 4'd1, 8'hFF, 0, 64'hF0, "sra_vl1");
      run_op(2'b01, 64'h80, 64'h03, 4'd1, 8'hFF, 0, 64'h10, "srl_vl1");
   endtask

   task automatic test_tail_clamp();
      run_op(2'b01, {8{8'hFF}}, {8{8'h01}}, 4'd3, 8'hFF, 0, 64'hFFFF_FFFF_FF7F_7F7F, "srl_tail");
      run_op(2'b01, {8{8'hFF}}, {8{8'h01}}, 4'd12, 8'hFF, 0, {8{8'h7F}}, "srl_clamp");
   endtask

   task automatic test_zero_reserved();
      run_op(2'b00, 64'h0123_4567_89AB_CDEF, {8{8'h01}}, 4'd0, 8'hFF, 5,
             64'h0123_4567_89AB_CDEF, "vl_zero_hold");
      run_op(2'b11, 64'hDEAD_BEEF_CAFE_F00D, {8{8'h02}}, 4'd5, 8'hFF, 5,
             64'hDEAD_BEEF_CAFE_F00D, "op_reserved_hold");
   endtask

   task automatic test_mask();
`ifdef VSHIFT_SEQ_MASK_EN
      run_op(2'b00, {8{8'h01}}, {8{8'h01}}, 4'd8, 8'h55, 0, 64'h0102_0102_0102_0102, "mask_55");
`else
      run_op(2'b00, {8{8'h01}}, {8{8'h01}}, 4'd8, 8'h55, 0, {8{8'h02}}, "mask_55");
`endif
   endtask

   task automatic test_reset_mid_run();
      int seen;
      @(negedge clk);
      op_valid = 1'b1; op = 2'b00; vs2 = {8{8'h11}}; vs1 = {8{8'h01}}; vl = 4'd8; vm = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (op_ready !== 1'b1 || res_valid !== 1'b0 || res_data !== 64'h0 || sh_src !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_mid_run: got rdy %b valid %b data %h src %h want 1 0 0 00",
                  op_ready, res_valid, res_data, sh_src);
      end
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      n_tests++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL reset_discard: got %0d valid cycles want 0", seen);
      end
      $display("[TB] reset at run index 4 checked");
      run_op(2'b01, {8{8'h40}}, {8{8'h02}}, 4'd8, 8'hFF, 0, {8{8'h10}}, "after_reset");
   endtask

   task automatic test_back_to_back();
      logic [1:0]  o;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  l;
      logic [7:0]  m;
      for (int k = 0; k < 20; k++) begin
         o = 2'($urandom_range(0, 3));
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         l = 4'($urandom_range(0, 10));
         m = 8'($urandom);
         run_op(o, a, b, l, m, int'($urandom_range(0, 2)), model(o, a, b, l, m), "random");
      end
   endtask

   initial begin
      rst = 1'b1; op_valid = 1'b0; op = 2'b00; vs2 = '0; vs1 = '0; vl = '0; vm = '0;
      res_ready = 1'b0;
      test_reset();
      test_sll();
      test_sra_srl();
      test_tail_clamp();
      test_zero_reserved();
      test_mask();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
